score_digit_scanner: RTL and testbench

- Upstream stage of the 7-segment display path.
- Holds the 4-digit BCD game score: incremented on each food-eaten pulse, cleared on new game.
- Produces four 5-bit digit codes, which feed the 4:1 digit multiplexer data inputs.
- Produces the 2-bit scan select, which drives that multiplexer's control, plus the matching active-low anode enables.

---
 rtl/score_pkg.sv | 11 +
 rtl/bcd_digit.sv | 19 +
 rtl/score_digit_scanner.sv | 106 ++++++++++
 tb/tb_score_digit_scanner.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared widths and codes for the score digit scanner and its decade counters.
package score_pkg;
  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 5;
  localparam int DP_BIT     = 4;
  localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;
  localparam logic [BCD_W-1:0] BCD_MAX    = 4'd9;

  typedef logic [DIGIT_W-1:0] digit_t;
endpackage

// File: rtl/bcd_digit.sv
// One BCD decade counter; carry_out fires when a carry pushes it past 9.
module bcd_digit
  import score_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             carry_in,
  output logic [BCD_W-1:0] value,
  output logic             carry_out
);
  assign carry_out = carry_in && (value == BCD_MAX);

  always_ff @(posedge clk) begin
    if (!resetn)       value <= '0;
    else if (clr)      value <= '0;
    else if (carry_in) value <= (value == BCD_MAX) ? '0 : value + 4'd1;
  end
endmodule

// File: rtl/score_digit_scanner.sv
// 4-digit BCD score with digit scan select/anode generation for the 7-seg mux.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (DIGIT0 always shown).
module score_digit_scanner
  import score_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int SCAN_W   = 17,
  parameter int SATURATE = 1
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       SCORE_INC,
  input  logic       SCORE_CLR,
  output logic [1:0] DIGIT_SEL,
  output digit_t     DIGIT0,
  output digit_t     DIGIT1,
  output digit_t     DIGIT2,
  output digit_t     DIGIT3,
  output logic [3:0] ANODE,
  output logic       OVERFLOW
);
  localparam bit SAT = (SATURATE != 0);

  // ---------------- scan ----------------
  logic [SCAN_W-1:0] pre;
  logic              tc;
  logic [1:0]        sel_next;

  assign tc       = (pre == SCAN_W'(SCAN_DIV - 1));
  assign sel_next = tc ? DIGIT_SEL + 2'd1 : DIGIT_SEL;

  // ANODE is computed from sel_next so it switches on the same edge as DIGIT_SEL.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      pre       <= '0;
      DIGIT_SEL <= 2'd0;
      ANODE     <= 4'b1110;
    end else begin
      pre       <= tc ? '0 : pre + 1'b1;
      DIGIT_SEL <= sel_next;
      ANODE     <= ~(4'b0001 << sel_next);
    end
  end

  // ---------------- score ----------------
  logic [NUM_DIGITS-1:0][BCD_W-1:0] bcd;
  logic [NUM_DIGITS:0]              carry;
  logic                             all9;

  always_comb begin
    all9 = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd[i] != BCD_MAX) all9 = 1'b0;
  end

  // Saturation just withholds the increment at 9999; the chain itself always wraps.
  assign carry[0] = SCORE_INC && !(SAT && all9);

  genvar g;
  for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .clk      (CLK),
      .resetn   (RESETN),
      .clr      (SCORE_CLR),
      .carry_in (carry[g]),
      .value    (bcd[g]),
      .carry_out(carry[g+1])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RESETN)        OVERFLOW <= 1'b0;
    else if (SCORE_CLR) OVERFLOW <= 1'b0;
    else if (carry[NUM_DIGITS] || (SAT && SCORE_INC && all9))
      OVERFLOW <= 1'b1;
  end

  // ---------------- digit codes ----------------
  logic [NUM_DIGITS-1:0][BCD_W-1:0] nib;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;
  always_comb begin
    blank = '0;
    blank[NUM_DIGITS-1] = (bcd[NUM_DIGITS-1] == '0);
    for (int i = NUM_DIGITS - 2; i >= 1; i--)
      blank[i] = blank[i+1] && (bcd[i] == '0);
    for (int i = 0; i < NUM_DIGITS; i++)
      nib[i] = blank[i] ? BLANK_CODE : bcd[i];
  end
`else
  assign nib = bcd;
`endif

  always_comb begin
    DIGIT0 = '0;
    DIGIT1 = '0;
    DIGIT2 = '0;
    DIGIT3 = '0;
    DIGIT0[BCD_W-1:0] = nib[0];
    DIGIT1[BCD_W-1:0] = nib[1];
    DIGIT2[BCD_W-1:0] = nib[2];
    DIGIT3[BCD_W-1:0] = nib[3];
    DIGIT3[DP_BIT]    = OVERFLOW;
  end
endmodule

// File: tb/tb_score_digit_scanner.sv
// Directed bench: a saturating and a wrapping instance driven by the same stimulus.
module tb_score_digit_scanner;
  import score_pkg::*;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       SCORE_INC = 1'b0;
  logic       SCORE_CLR = 1'b0;

  logic [1:0] sel_s, sel_w;
  digit_t     d0_s, d1_s, d2_s, d3_s, d0_w, d1_w, d2_w, d3_w;
  logic [3:0] an_s, an_w;
  logic       ovf_s, ovf_w;

  int n_chk = 0;
  int n_fail = 0;
  int edges = 0;

  always #5 CLK = ~CLK;

  score_digit_scanner #(.SCAN_DIV(4), .SCAN_W(3), .SATURATE(1)) u_sat (
    .CLK(CLK), .RESETN(RESETN), .SCORE_INC(SCORE_INC), .SCORE_CLR(SCORE_CLR),
    .DIGIT_SEL(sel_s), .DIGIT0(d0_s), .DIGIT1(d1_s), .DIGIT2(d2_s), .DIGIT3(d3_s),
    .ANODE(an_s), .OVERFLOW(ovf_s));

  score_digit_scanner #(.SCAN_DIV(4), .SCAN_W(3), .SATURATE(0)) u_wrap (
    .CLK(CLK), .RESETN(RESETN), .SCORE_INC(SCORE_INC), .SCORE_CLR(SCORE_CLR),
    .DIGIT_SEL(sel_w), .DIGIT0(d0_w), .DIGIT1(d1_w), .DIGIT2(d2_w), .DIGIT3(d3_w),
    .ANODE(an_w), .OVERFLOW(ovf_w));

  // Independent scan reference: edges since reset, slot = (edges/4) mod 4.
  always @(posedge CLK)
    if (!RESETN) edges <= 0;
    else         edges <= edges + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_nib(input int s);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'((s / 1000) % 10);
    d2 = 4'((s / 100) % 10);
    d1 = 4'((s / 10) % 10);
    d0 = 4'(s % 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (d3 == 0) begin
      d3 = 4'hF;
      if (d2 == 0) begin
        d2 = 4'hF;
        if (d1 == 0) d1 = 4'hF;
      end
    end
`endif
    return {d3, d2, d1, d0};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      SCORE_INC = 1'b1; tick;
      SCORE_INC = 1'b0; tick;
    end
  endtask

  task automatic chk_score(input string tag, input int s_sat, input int s_wrap,
                           input logic o_sat, input logic o_wrap);
    chk({tag, "_sat"},  {16'h0, d3_s[3:0], d2_s[3:0], d1_s[3:0], d0_s[3:0]}, {16'h0, exp_nib(s_sat)});
    chk({tag, "_wrap"}, {16'h0, d3_w[3:0], d2_w[3:0], d1_w[3:0], d0_w[3:0]}, {16'h0, exp_nib(s_wrap)});
    chk({tag, "_ovf_sat"},  {31'h0, ovf_s}, {31'h0, o_sat});
    chk({tag, "_ovf_wrap"}, {31'h0, ovf_w}, {31'h0, o_wrap});
    chk({tag, "_dp_sat"},  {29'h0, d0_s[4], d1_s[4], d2_s[4]}, 32'h0);
    chk({tag, "_dp3_sat"}, {31'h0, d3_s[4]}, {31'h0, o_sat});
    chk({tag, "_dp3_wrap"}, {31'h0, d3_w[4]}, {31'h0, o_wrap});
  endtask

  task automatic chk_scan(input string tag);
    logic [1:0] s;
    s = 2'((edges / 4) % 4);
    chk({tag, "_sel_s"}, {30'h0, sel_s}, {30'h0, s});
    chk({tag, "_sel_w"}, {30'h0, sel_w}, {30'h0, s});
    chk({tag, "_an_s"},  {28'h0, an_s}, {28'h0, ~(4'b0001 << s)});
    chk({tag, "_an_w"},  {28'h0, an_w}, {28'h0, ~(4'b0001 << s)});
  endtask

  initial begin
    logic [3:0] an_tab [4];
    logic       hit;
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;

    // reset state
    tick; tick;
    chk("rst_sel", {30'h0, sel_s}, 32'h0);
    chk("rst_an",  {28'h0, an_s}, 32'he);
    chk_score("rst", 0, 0, 1'b0, 1'b0);

    // idle scan: slot advances every 4 cycles, 0,1,2,3,0
    RESETN = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick;
      chk_scan("scan");
      if (k % 4 == 0) begin
        chk("scan_tab_sel", {30'h0, sel_s}, 32'((k / 4) % 4));
        chk("scan_tab_an",  {28'h0, an_s}, {28'h0, an_tab[(k / 4) % 4]});
      end
    end
    chk_score("idle", 0, 0, 1'b0, 1'b0);

    // 0057 then CLR and INC together
    pulse(57);
    chk_score("s57", 57, 57, 1'b0, 1'b0);
    SCORE_CLR = 1'b1; SCORE_INC = 1'b1; tick;
    SCORE_CLR = 1'b0; SCORE_INC = 1'b0;
    chk_score("clr_inc", 0, 0, 1'b0, 1'b0);
    chk_scan("clr_scan");

    // 42 (leading-zero display case)
    pulse(42);
    chk_score("s42", 42, 42, 1'b0, 1'b0);
    SCORE_CLR = 1'b1; tick; SCORE_CLR = 1'b0;

    // ripple 0999 -> 1000
    pulse(999);
    chk_score("s999", 999, 999, 1'b0, 1'b0);
    SCORE_INC = 1'b1; tick; SCORE_INC = 1'b0;
    chk_score("s1000", 1000, 1000, 1'b0, 1'b0);
    chk_scan("ripple_scan");

    // mid-prescale reset at slot 2 with score 0123
    SCORE_CLR = 1'b1; tick; SCORE_CLR = 1'b0;
    pulse(123);
    chk_score("s123", 123, 123, 1'b0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 32 && !hit; i++) begin
      if (((edges / 4) % 4 == 2) && (edges % 4 == 1)) hit = 1'b1;
      else tick;
    end
    chk("mid_found", {31'h0, hit}, 32'h1);
    chk("mid_sel", {30'h0, sel_s}, 32'h2);
    RESETN = 1'b0; tick; RESETN = 1'b1;
    chk("mrst_sel", {30'h0, sel_s}, 32'h0);
    chk("mrst_an",  {28'h0, an_s}, 32'he);
    chk_score("mrst", 0, 0, 1'b0, 1'b0);
    tick; tick; tick;
    chk("mrst_hold_sel", {30'h0, sel_s}, 32'h0);
    tick;
    chk("mrst_step_sel", {30'h0, sel_s}, 32'h1);
    chk("mrst_step_an",  {28'h0, an_s}, 32'hd);

    // 9998 then three more increments
    SCORE_INC = 1'b1;
    repeat (9998) tick;
    chk_score("s9998", 9998, 9998, 1'b0, 1'b0);
    tick; chk_score("ov1", 9999, 9999, 1'b0, 1'b0);
    tick; chk_score("ov2", 9999, 0, 1'b1, 1'b1);
    tick; chk_score("ov3", 9999, 1, 1'b1, 1'b1);
    SCORE_INC = 1'b0;
    tick; chk_score("ov_hold", 9999, 1, 1'b1, 1'b1);
    SCORE_CLR = 1'b1; tick; SCORE_CLR = 1'b0;
    chk_score("ov_clr", 0, 0, 1'b0, 1'b0);
    chk_scan("end_scan");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
